// File: rtl/set_count_n.sv
`default_nettype none
// ============================================================================
// Module   : set_count_n
// Function : Raster-scans a GRIDxGRID lattice and counts the points that
//            satisfy a set operation over up to NCIRC masked circles.
//            Optional macro SET_PIPE_EN adds a register stage between the
//            membership evaluation and the counter.
// Revision : 1.0
// ============================================================================
module set_count_n #(
    parameter int NCIRC = 4,
    parameter int GRID  = 8,
    parameter int CW    = 4,
    parameter int CNTW  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NCIRC*2*CW-1:0]   central,
    input  logic [NCIRC*CW-1:0]     radius,
    input  logic [NCIRC-1:0]        mask,
    input  logic [2:0]              mode,
    input  logic [3:0]              k,
    output logic                    busy,
    output logic                    valid,
    output logic [CNTW-1:0]         candidate
);

    localparam logic [1:0]    ST_IDLE = 2'd0;
    localparam logic [1:0]    ST_SCAN = 2'd1;
    localparam logic [1:0]    ST_DONE = 2'd2;
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] GRID_C  = CW'(GRID);

    logic [1:0]              state_q, state_d;
    logic [CW-1:0]           x_q, x_d, y_q, y_d;
    logic [CNTW-1:0]         count_q, count_d;
    logic [CNTW-1:0]         cand_q, cand_d;
    logic [NCIRC*2*CW-1:0]   cen_q, cen_d;
    logic [NCIRC*CW-1:0]     rad_q, rad_d;
    logic [NCIRC-1:0]        mask_q, mask_d;
    logic [2:0]              mode_q, mode_d;
    logic [3:0]              k_q, k_d;

    logic [NCIRC-1:0]        in_w;
    logic [3:0]              n_w, pop_w;
    logic                    hit_w, add_w, accept_w, last_pt_w;

    // Per-circle membership, computed at full precision so large radii never wrap
    for (genvar gi = 0; gi < NCIRC; gi++) begin : g_circ
        logic [CW-1:0]   cx, cy, r, dx, dy;
        logic [2*CW:0]   d2;
        logic [2*CW:0]   r2;
        assign cx = cen_q[(2*gi+2)*CW-1 -: CW];
        assign cy = cen_q[(2*gi+1)*CW-1 -: CW];
        assign r  = rad_q[(gi+1)*CW-1 -: CW];
        assign dx = (cx > x_q) ? (cx - x_q) : (x_q - cx);
        assign dy = (cy > y_q) ? (cy - y_q) : (y_q - cy);
        assign d2 = ((2*CW+1)'(dx) * (2*CW+1)'(dx)) + ((2*CW+1)'(dy) * (2*CW+1)'(dy));
        assign r2 = (2*CW+1)'(r) * (2*CW+1)'(r);
        assign in_w[gi] = (d2 <= r2);
    end

    always_comb begin
        n_w   = '0;
        pop_w = '0;
        for (int i = 0; i < NCIRC; i++) begin
            n_w   = n_w + 4'(in_w[i] & mask_q[i]);
            pop_w = pop_w + 4'(mask_q[i]);
        end
    end

    always_comb begin
        case (mode_q)
            3'd0:    hit_w = (n_w == pop_w) && (mask_q != '0);
            3'd1:    hit_w = (n_w != 4'd0);
            3'd2:    hit_w = n_w[0];
            3'd3:    hit_w = (n_w == k_q);
            3'd4:    hit_w = (n_w >= k_q);
            default: hit_w = 1'b0;
        endcase
    end

    assign accept_w  = en && (state_q != ST_SCAN);
    assign last_pt_w = (x_q == GRID_C) && (y_q == GRID_C);

`ifdef SET_PIPE_EN
    logic hit_q, hit_d, drain_q, drain_d;
    assign add_w   = hit_q;
    // drain_q marks the extra cycle that folds the last registered hit into the count
    assign hit_d   = (state_q == ST_SCAN && !drain_q) ? hit_w : 1'b0;
    assign drain_d = (state_q == ST_SCAN) && !drain_q && last_pt_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q   <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            hit_q   <= hit_d;
            drain_q <= drain_d;
        end
    end
`else
    assign add_w = hit_w;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        count_d = count_q;
        cand_d  = cand_q;
        cen_d   = cen_q;
        rad_d   = rad_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        k_d     = k_q;

        case (state_q)
            ST_SCAN: begin
                count_d = count_q + CNTW'(add_w);
`ifdef SET_PIPE_EN
                if (drain_q) begin
                    state_d = ST_DONE;
                    cand_d  = count_d;
                end else if (last_pt_w) begin
                    x_d = ONE;
                    y_d = ONE;
                end else if (x_q == GRID_C) begin
                    x_d = ONE;
                    y_d = y_q + ONE;
                end else begin
                    x_d = x_q + ONE;
                end
`else
                if (last_pt_w) begin
                    x_d     = ONE;
                    y_d     = ONE;
                    state_d = ST_DONE;
                    cand_d  = count_d;
                end else if (x_q == GRID_C) begin
                    x_d = ONE;
                    y_d = y_q + ONE;
                end else begin
                    x_d = x_q + ONE;
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept_w) begin
            state_d = ST_SCAN;
            x_d     = ONE;
            y_d     = ONE;
            count_d = '0;
            cand_d  = '0;
            cen_d   = central;
            rad_d   = radius;
            mask_d  = mask;
            mode_d  = mode;
            k_d     = k;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= ONE;
            y_q     <= ONE;
            count_q <= '0;
            cand_q  <= '0;
            cen_q   <= '0;
            rad_q   <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            count_q <= count_d;
            cand_q  <= cand_d;
            cen_q   <= cen_d;
            rad_q   <= rad_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
        end
    end

    assign busy      = (state_q == ST_SCAN);
    assign valid     = (state_q == ST_DONE);
    assign candidate = cand_q;

endmodule
`default_nettype wire

// File: tb/tb_set_count_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_set_count_n
// Function : Directed self-checking bench for set_count_n (default params).
// Revision : 1.0
// ============================================================================
module tb_set_count_n;

`ifdef SET_PIPE_EN
    localparam int LAT = 65;
`else
    localparam int LAT = 64;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] central;
    logic [15:0] radius;
    logic [3:0]  mask;
    logic [2:0]  mode;
    logic [3:0]  k;
    logic        busy;
    logic        valid;
    logic [7:0]  candidate;

    int n_cmp = 0;
    int n_bad = 0;

    set_count_n #(.NCIRC(4), .GRID(8), .CW(4), .CNTW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .central   (central),
        .radius    (radius),
        .mask      (mask),
        .mode      (mode),
        .k         (k),
        .busy      (busy),
        .valid     (valid),
        .candidate (candidate)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a configuration with en for one edge; returns #1 after that edge.
    task automatic start(input logic [31:0] c, input logic [15:0] r, input logic [3:0] m,
                         input logic [2:0] md, input logic [3:0] kk);
        central = c;
        radius  = r;
        mask    = m;
        mode    = md;
        k       = kk;
        en      = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    // c0 = edges already elapsed since the accepting edge.
    task automatic wait_valid(input string tag, input int exp, input int c0);
        int c;
        c = c0;
        while (valid !== 1'b1 && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        check({tag, "_latency"}, c, LAT);
        check({tag, "_count"}, candidate, exp);
        check({tag, "_busy_at_valid"}, busy, 0);
    endtask

    task automatic run(input string tag, input logic [31:0] c, input logic [15:0] r,
                       input logic [3:0] m, input logic [2:0] md, input logic [3:0] kk,
                       input int exp);
        start(c, r, m, md, kk);
        check({tag, "_busy_start"}, busy, 1);
        check({tag, "_cand_cleared"}, candidate, 0);
        wait_valid(tag, exp, 0);
        @(posedge clk);
        #1;
        check({tag, "_valid_one_cycle"}, valid, 0);
        check({tag, "_hold"}, candidate, exp);
    endtask

    initial begin
        int seen;
        rst     = 1'b1;
        en      = 1'b0;
        central = '0;
        radius  = '0;
        mask    = '0;
        mode    = '0;
        k       = '0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_valid", valid, 0);
        check("reset_cand", candidate, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run("all_single",   32'h0000_0044, 16'h0002, 4'b0001, 3'd0, 4'd0, 13);
        run("odd_two",      32'h0000_6633, 16'h0022, 4'b0011, 3'd2, 4'd0, 26);
        run("any_two",      32'h0000_6633, 16'h0022, 4'b0011, 3'd1, 4'd0, 26);
        run("all_two",      32'h0000_6633, 16'h0022, 4'b0011, 3'd0, 4'd0, 0);
        run("exact_k2",     32'h0055_5555, 16'h0111, 4'b0111, 3'd3, 4'd2, 0);
        run("exact_k3",     32'h0055_5555, 16'h0111, 4'b0111, 3'd3, 4'd3, 5);
        run("atleast_k1",   32'h0055_5555, 16'h0111, 4'b0111, 3'd4, 4'd1, 5);
        run("any_nomask",   32'h0055_5555, 16'h0111, 4'b0000, 3'd1, 4'd0, 0);
        run("reserved6",    32'h0055_5555, 16'h0111, 4'b0111, 3'd6, 4'd0, 0);
        run("r0_corner",    32'h0000_0011, 16'h0000, 4'b0001, 3'd1, 4'd0, 1);
        run("r15_full",     32'h0000_0088, 16'h000F, 4'b0001, 3'd1, 4'd0, 64);

        // Reset 20 cycles into a scan: outputs clear at once, no valid follows
        start(32'h0000_0044, 16'h0002, 4'b0001, 3'd0, 4'd0);
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid, 0);
        check("midrst_cand", candidate, 0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) seen++;
        end
        check("midrst_no_valid", seen, 0);
        run("after_rst", 32'h0000_0044, 16'h0002, 4'b0001, 3'd0, 4'd0, 13);

        // en re-pulsed mid-scan with another configuration is ignored
        start(32'h0000_0044, 16'h0002, 4'b0001, 3'd0, 4'd0);
        repeat (10) @(posedge clk);
        #1;
        central = 32'h0000_0088;
        radius  = 16'h000F;
        mode    = 3'd1;
        en      = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        wait_valid("ignore_en", 13, 11);

        // Back-to-back: en during DONE starts a new scan on the next edge
        central = 32'h0000_0011;
        radius  = 16'h0000;
        mask    = 4'b0001;
        mode    = 3'd1;
        en      = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_valid", valid, 0);
        check("b2b_cand", candidate, 0);
        wait_valid("b2b", 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/set_count_n.md
SET_COUNT_N -- requirements
Module: set_count_n

Interface
REQ-001 The block SHALL have parameter NCIRC, default 4, number of circles evaluated (legal range 2..8).
REQ-002 The block SHALL have parameter GRID, default 8, grid side length; coordinates span 1..GRID on both axes.
REQ-003 The block SHALL have parameter CW, default 4, coordinate and radius width in bits.
REQ-004 The block SHALL have parameter CNTW, default 8, candidate width, which SHALL be at least ceil(log2(GRID*GRID+1)).
REQ-005 clk  input  1  clock; all state SHALL be updated on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  start request.
REQ-008 central  input  NCIRC*2*CW  circle centres; circle i = {x,y} at bits [(2i+2)*CW-1 : 2i*CW], with x as the upper CW bits.
REQ-009 radius  input  NCIRC*CW  radii; circle i at bits [(i+1)*CW-1 : i*CW].
REQ-010 mask  input  NCIRC  circle-enable mask; bit i set means circle i participates.
REQ-011 mode  input  3  set operation.
REQ-012 k  input  4  threshold for modes EXACT and ATLEAST.
REQ-013 busy  output  1  scan in progress.
REQ-014 valid  output  1  one-cycle result strobe.
REQ-015 candidate  output  CNTW  count of grid points satisfying the set operation.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-017 en SHALL be accepted only in IDLE or DONE; acceptance latches central, radius, mask, mode and k, clears the internal count, sets x=1, y=1, and enters SCAN; en SHALL be ignored while in SCAN.
REQ-018 In SCAN the block SHALL evaluate one point per cycle in raster order, x fastest (1..GRID), then y (1..GRID), GRID*GRID cycles in total.
REQ-019 Point membership in circle i SHALL be dx*dx+dy*dy <= r*r, boundary inclusive, with dx and dy as absolute differences and the sum held in 2*CW+1 bits without truncation.
REQ-020 Let n be the number of circles with mask bit set that contain the point; modes SHALL be 0 ALL (n equals popcount(mask) and mask nonzero), 1 ANY (n>=1), 2 ODD (n odd), 3 EXACT (n==k), 4 ATLEAST (n>=k), and 5..7 reserved, which never count.
REQ-021 After evaluating point (GRID,GRID) the FSM SHALL enter DONE for exactly one cycle, with valid=1, busy=0 and candidate equal to the final count.
REQ-022 With en sampled at edge T, busy SHALL be 1 from T through the edge before valid, and valid SHALL be 1 in the cycle following edge T+GRID*GRID (base build).
REQ-023 candidate SHALL be registered, SHALL hold its value after valid until the next accepted en, and SHALL then read 0 until the scan updates it.
REQ-024 en asserted during DONE SHALL start a new scan with no idle cycle (back-to-back operation).

Reset
REQ-025 rst SHALL asynchronously force IDLE, busy=0, valid=0, candidate=0, x=1, y=1 and the latched configuration to 0.
REQ-026 rst asserted mid-scan SHALL discard the scan with no valid pulse, and the next en after rst deasserts SHALL start a clean scan.

Configuration
REQ-027 Macro SET_PIPE_EN, when defined, SHALL insert one register stage between membership evaluation and the counter, so valid arrives one cycle later (GRID*GRID+1 cycles after the en edge) and busy extends by one cycle; when undefined, membership SHALL feed the counter combinationally within the same cycle; counts SHALL be identical in both builds.

Verification
REQ-028 Defaults, circle0 centre (4,4), r=2, mask=0001, mode=ALL -> candidate=13; valid in the cycle after edge T+64 (T+65 with SET_PIPE_EN).
REQ-029 Circles (3,3) r=2 and (6,6) r=2, mask=0011 -> ODD=26, ANY=26, ALL=0.
REQ-030 Three circles at (5,5) r=1, mask=0111 -> EXACT k=2 gives 0, EXACT k=3 gives 5, ATLEAST k=1 gives 5; mask=0000 with ANY gives 0; mode=6 gives 0.
REQ-031 Circle (1,1) r=0 -> candidate=1; circle (8,8) r=15 with ANY -> candidate=64 (no overflow).
REQ-032 rst pulse 20 cycles into a scan -> busy=0, valid=0, candidate=0 immediately and no valid pulse; a subsequent en gives the correct count.
REQ-033 en re-pulsed mid-scan with different inputs -> ignored, original result returned; en held during the DONE cycle -> new scan starts on the next edge.
